// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RISC-V core: issues req/ack data-memory accesses and formats loads/stores.
// Build option MEM_TIMEOUT_EN adds an ack timeout that abandons the access and pulses bus_err.
module mem_access_stage #(
   parameter int data_bits      = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [2:0]           funct3,
   input  logic [data_bits-1:0] alu_result,
   input  logic [data_bits-1:0] store_data,
   input  logic [4:0]           rd_in,
   input  logic                 flush,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [data_bits-1:0] dmem_addr,
   output logic [3:0]           dmem_be,
   output logic [data_bits-1:0] dmem_wdata,
   input  logic [data_bits-1:0] dmem_rdata,
   input  logic                 dmem_ack,
   output logic                 stall,
   output logic [data_bits-1:0] alu_result_out,
   output logic [data_bits-1:0] data_memory_out,
   output logic [4:0]           rd_out,
   output logic                 out_valid,
`ifdef MEM_TIMEOUT_EN
   output logic                 bus_err,
`endif
   output logic                 misalign_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state;
   logic [data_bits-1:0] lat_addr;
   logic [4:0]           lat_rd;
   logic [2:0]           lat_funct3;
   logic                 lat_load;
   logic                 squashed;

   logic                 is_mem;
   logic                 misaligned;
   logic                 accept;
   logic                 timeout_hit;
   logic [3:0]           store_be;
   logic [data_bits-1:0] store_wdata;
   logic [7:0]           sel_byte;
   logic [15:0]          sel_half;
   logic [data_bits-1:0] load_data;

   assign is_mem = mem_read | mem_write;
   assign accept = (state == IDLE) && in_valid && !flush && is_mem && !misaligned;
   assign stall  = accept || ((state == BUSY) && !dmem_ack && !timeout_hit);

   // Reserved size encodings (011, 110, 111) are reported as misaligned.
   always_comb begin
      misaligned = 1'b1;
      case (funct3)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = alu_result[0];
         3'b010:         misaligned = |alu_result[1:0];
         default:        misaligned = 1'b1;
      endcase
   end

   always_comb begin
      store_be    = 4'hF;
      store_wdata = '0;
      if (mem_write) begin
         case (funct3[1:0])
            2'b00: begin
               store_be    = 4'b0001 << alu_result[1:0];
               store_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
               store_be    = 4'b0011 << alu_result[1:0];
               store_wdata = {2{store_data[15:0]}};
            end
            default: store_wdata = store_data;
         endcase
      end
   end

   // Load formatting works from the latched address because the inputs may already be stale on ack.
   always_comb begin
      case (lat_addr[1:0])
         2'd0:    sel_byte = dmem_rdata[7:0];
         2'd1:    sel_byte = dmem_rdata[15:8];
         2'd2:    sel_byte = dmem_rdata[23:16];
         default: sel_byte = dmem_rdata[31:24];
      endcase
      sel_half = lat_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (lat_funct3)
         3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_data = {24'b0, sel_byte};
         3'b101:  load_data = {16'b0, sel_half};
         default: load_data = dmem_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (state == BUSY) && !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if (!dmem_ack) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= '0;
         dmem_be         <= 4'h0;
         dmem_wdata      <= '0;
         alu_result_out  <= '0;
         data_memory_out <= '0;
         rd_out          <= 5'd0;
         out_valid       <= 1'b0;
         misalign_err    <= 1'b0;
         lat_addr        <= '0;
         lat_rd          <= 5'd0;
         lat_funct3      <= 3'd0;
         lat_load        <= 1'b0;
         squashed        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         bus_err         <= 1'b0;
`endif
      end else begin
         out_valid       <= 1'b0;
         misalign_err    <= 1'b0;
         rd_out          <= 5'd0;
         data_memory_out <= '0;
         alu_result_out  <= alu_result;
`ifdef MEM_TIMEOUT_EN
         bus_err         <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (in_valid && !flush) begin
                  if (!is_mem) begin
                     out_valid <= 1'b1;
                     rd_out    <= rd_in;
                  end else if (misaligned) begin
                     out_valid    <= 1'b1;
                     misalign_err <= 1'b1;
                  end else begin
                     state      <= BUSY;
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_write;
                     dmem_addr  <= {alu_result[data_bits-1:2], 2'b00};
                     dmem_be    <= store_be;
                     dmem_wdata <= store_wdata;
                     lat_addr   <= alu_result;
                     lat_rd     <= rd_in;
                     lat_funct3 <= funct3;
                     lat_load   <= !mem_write;
                     squashed   <= 1'b0;
                  end
               end
            end
            BUSY: begin
               alu_result_out <= lat_addr;
               if (flush) squashed <= 1'b1;
               // A flushed access still runs to completion; only its result is hidden.
               if (dmem_ack) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (!squashed && !flush) begin
                     out_valid <= 1'b1;
                     if (lat_load) begin
                        data_memory_out <= load_data;
                        rd_out          <= lat_rd;
                     end
                  end
               end else if (timeout_hit) begin
                  state     <= IDLE;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  out_valid <= !(squashed || flush);
`ifdef MEM_TIMEOUT_EN
                  bus_err   <= 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a reference model.
module tb_mem_access_stage;

   logic        clk, rst;
   logic        in_valid, mem_read, mem_write, flush;
   logic [2:0]  funct3;
   logic [31:0] alu_result, store_data;
   logic [4:0]  rd_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall, out_valid, misalign_err;
   logic [31:0] alu_result_out, data_memory_out;
   logic [4:0]  rd_out;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err;
`endif

   int passed = 0;
   int total  = 0;

   mem_access_stage #(.data_bits(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
      .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .alu_result_out(alu_result_out), .data_memory_out(data_memory_out),
      .rd_out(rd_out), .out_valid(out_valid),
`ifdef MEM_TIMEOUT_EN
      .bus_err(bus_err),
`endif
      .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: access size from funct3, lane from the low address bits, plain arithmetic.
   function automatic void model(input bit wr, input bit [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sd, input logic [31:0] rdata,
                                 output bit mis, output logic [3:0] be,
                                 output logic [31:0] wd, output logic [31:0] ld);
      int size, lane;
      logic [31:0] v;
      lane = int'(addr[1:0]);
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (size == 0) mis = 1'b1;
      else           mis = (lane % size) != 0;
      be = wr ? 4'((((1 << size) - 1) << lane)) : 4'hF;
      if (size == 1)      wd = (sd & 32'hFF) * 32'h0101_0101;
      else if (size == 2) wd = (sd & 32'hFFFF) * 32'h0001_0001;
      else                wd = sd;
      v = rdata >> (8 * lane);
      if (size == 1) begin
         v = v & 32'hFF;
         if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
         v = v & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rdata;
      end
      ld = v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
      funct3 = 3'd0; alu_result = '0; store_data = '0; rd_in = 5'd0;
   endtask

   task automatic run_alu_op(input string name, input logic [31:0] val, input logic [4:0] rd);
      in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
      alu_result = val; rd_in = rd; funct3 = 3'($urandom_range(0, 7));
      #1;
      total++; if (stall !== 1'b0) $display("[TB] FAIL %s stall: got %0b want 0", name, stall); else passed++;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("[TB] FAIL %s out_valid: got %0b want 1", name, out_valid); else passed++;
      total++; if (alu_result_out !== val) $display("[TB] FAIL %s alu_result_out: got %h want %h", name, alu_result_out, val); else passed++;
      total++; if (rd_out !== rd) $display("[TB] FAIL %s rd_out: got %0d want %0d", name, rd_out, rd); else passed++;
      total++; if (data_memory_out !== 32'd0) $display("[TB] FAIL %s data_memory_out: got %h want 0", name, data_memory_out); else passed++;
      total++; if (misalign_err !== 1'b0) $display("[TB] FAIL %s misalign_err: got %0b want 0", name, misalign_err); else passed++;
   endtask

   task automatic run_mem_op(input string name, input bit wr, input bit [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input logic [31:0] rdata, input logic [4:0] rd,
                             input int delay, input bit flush_busy, output int stall_cycles);
      bit mis;
      logic [3:0] ebe;
      logic [31:0] ewd, eld;
      model(wr, f3, addr, sd, rdata, mis, ebe, ewd, eld);
      stall_cycles = 0;
      in_valid = 1'b1; mem_read = !wr; mem_write = wr; funct3 = f3;
      alu_result = addr; store_data = sd; rd_in = rd; flush = 1'b0;
      #1;
      if (mis) begin
         total++; if (stall !== 1'b0) $display("[TB] FAIL %s misaligned stall: got %0b want 0", name, stall); else passed++;
         tick();
         in_valid = 1'b0;
         total++; if (out_valid !== 1'b1) $display("[TB] FAIL %s misaligned out_valid: got %0b want 1", name, out_valid); else passed++;
         total++; if (misalign_err !== 1'b1) $display("[TB] FAIL %s misalign_err: got %0b want 1", name, misalign_err); else passed++;
         total++; if (rd_out !== 5'd0) $display("[TB] FAIL %s misaligned rd_out: got %0d want 0", name, rd_out); else passed++;
         total++; if (dmem_req !== 1'b0) $display("[TB] FAIL %s misaligned dmem_req: got %0b want 0", name, dmem_req); else passed++;
         return;
      end
      total++; if (stall !== 1'b1) $display("[TB] FAIL %s accept stall: got %0b want 1", name, stall); else passed++;
      if (stall === 1'b1) stall_cycles++;
      tick();
      total++; if (dmem_req !== 1'b1) $display("[TB] FAIL %s dmem_req: got %0b want 1", name, dmem_req); else passed++;
      total++; if (dmem_we !== wr) $display("[TB] FAIL %s dmem_we: got %0b want %0b", name, dmem_we, wr); else passed++;
      total++; if (dmem_addr !== (addr & 32'hFFFF_FFFC)) $display("[TB] FAIL %s dmem_addr: got %h want %h", name, dmem_addr, addr & 32'hFFFF_FFFC); else passed++;
      total++; if (dmem_be !== ebe) $display("[TB] FAIL %s dmem_be: got %h want %h", name, dmem_be, ebe); else passed++;
      if (wr) begin
         total++; if (dmem_wdata !== ewd) $display("[TB] FAIL %s dmem_wdata: got %h want %h", name, dmem_wdata, ewd); else passed++;
      end
      flush = flush_busy;
      for (int i = 0; i < delay; i++) begin
         total++; if (stall !== 1'b1) $display("[TB] FAIL %s wait stall: got %0b want 1", name, stall); else passed++;
         if (stall === 1'b1) stall_cycles++;
         tick();
         flush = 1'b0;
         total++; if (dmem_req !== 1'b1) $display("[TB] FAIL %s held dmem_req: got %0b want 1", name, dmem_req); else passed++;
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      total++; if (stall !== 1'b0) $display("[TB] FAIL %s ack stall: got %0b want 0", name, stall); else passed++;
      tick();
      dmem_ack = 1'b0; dmem_rdata = $urandom; in_valid = 1'b0; flush = 1'b0;
      total++; if (dmem_req !== 1'b0) $display("[TB] FAIL %s dmem_req after ack: got %0b want 0", name, dmem_req); else passed++;
      total++; if (out_valid !== !flush_busy) $display("[TB] FAIL %s out_valid: got %0b want %0b", name, out_valid, !flush_busy); else passed++;
      total++; if (rd_out !== ((flush_busy || wr) ? 5'd0 : rd)) $display("[TB] FAIL %s rd_out: got %0d want %0d", name, rd_out, (flush_busy || wr) ? 5'd0 : rd); else passed++;
      if (!flush_busy) begin
         total++; if (alu_result_out !== addr) $display("[TB] FAIL %s alu_result_out: got %h want %h", name, alu_result_out, addr); else passed++;
         total++; if (data_memory_out !== (wr ? 32'd0 : eld)) $display("[TB] FAIL %s data_memory_out: got %h want %h", name, data_memory_out, wr ? 32'd0 : eld); else passed++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
      idle_inputs();
      #1;
      total++; if (dmem_req !== 1'b0) $display("[TB] FAIL reset dmem_req: got %0b want 0", dmem_req); else passed++;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %0b want 0", out_valid); else passed++;
      total++; if ({dmem_addr, dmem_wdata, dmem_be} !== 68'd0) $display("[TB] FAIL reset dmem bus: got %h want 0", {dmem_addr, dmem_wdata, dmem_be}); else passed++;
      total++; if ({alu_result_out, data_memory_out, rd_out} !== 69'd0) $display("[TB] FAIL reset results: got %h want 0", {alu_result_out, data_memory_out, rd_out}); else passed++;
      tick(); tick();
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_busy();
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2;
      alu_result = 32'h0000_0040; rd_in = 5'd9;
      tick(); tick();
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      total++; if (dmem_req !== 1'b0) $display("[TB] FAIL rst_busy dmem_req: got %0b want 0", dmem_req); else passed++;
      total++; if ({out_valid, misalign_err, rd_out, dmem_be} !== 11'd0) $display("[TB] FAIL rst_busy outputs: got %h want 0", {out_valid, misalign_err, rd_out, dmem_be}); else passed++;
      total++; if (stall !== 1'b0) $display("[TB] FAIL rst_busy stall: got %0b want 0", stall); else passed++;
      #1 rst = 1'b0;
      idle_inputs();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_ack = 1'b0;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL late_ack out_valid: got %0b want 0", out_valid); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL late_ack out_valid2: got %0b want 0", out_valid); else passed++;
   endtask

   task automatic test_load_format();
      int sc;
      run_mem_op("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 5'd7, 0, 1'b0, sc);
      total++; if (data_memory_out !== 32'hFFFF_FF80) $display("[TB] FAIL lb_value: got %h want ffffff80", data_memory_out); else passed++;
      run_mem_op("lbu_0x103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 5'd8, 1, 1'b0, sc);
      total++; if (data_memory_out !== 32'h0000_0080) $display("[TB] FAIL lbu_value: got %h want 00000080", data_memory_out); else passed++;
      run_mem_op("lh_0x102", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 5'd3, 0, 1'b0, sc);
      run_mem_op("lhu_0x102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_7F01, 5'd4, 0, 1'b0, sc);
   endtask

   task automatic test_store_half();
      int sc;
      run_mem_op("sh_0x202", 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0, 5'd6, 4, 1'b0, sc);
      total++; if (sc !== 5) $display("[TB] FAIL sh_stall_cycles: got %0d want 5", sc); else passed++;
      run_mem_op("sb_0x201", 1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 5'd6, 0, 1'b0, sc);
   endtask

   task automatic test_misalign();
      int sc;
      run_mem_op("lw_0x301", 1'b0, 3'b010, 32'h301, 32'h0, 32'h0, 5'd12, 0, 1'b0, sc);
      run_mem_op("sh_0x303", 1'b1, 3'b001, 32'h303, 32'h5555, 32'h0, 5'd2, 0, 1'b0, sc);
      run_mem_op("f3_011", 1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 5'd2, 0, 1'b0, sc);
   endtask

   task automatic test_flush();
      int sc;
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2;
      alu_result = 32'h400; rd_in = 5'd11; flush = 1'b1;
      #1;
      total++; if (stall !== 1'b0) $display("[TB] FAIL idle_flush stall: got %0b want 0", stall); else passed++;
      tick();
      idle_inputs();
      total++; if ({out_valid, dmem_req, rd_out} !== 7'd0) $display("[TB] FAIL idle_flush outputs: got %h want 0", {out_valid, dmem_req, rd_out}); else passed++;
      run_mem_op("busy_flush", 1'b0, 3'b010, 32'h500, 32'h0, 32'h1111_2222, 5'd13, 2, 1'b1, sc);
      run_mem_op("ack_flush", 1'b0, 3'b010, 32'h504, 32'h0, 32'h3333_4444, 5'd14, 0, 1'b1, sc);
   endtask

   task automatic test_back_to_back();
      int sc;
      run_alu_op("alu_0x1234", 32'h0000_1234, 5'd5);
      run_mem_op("b2b_lw", 1'b0, 3'b010, 32'h600, 32'h0, 32'hCAFE_F00D, 5'd15, 0, 1'b0, sc);
      run_alu_op("b2b_alu", 32'h8000_0001, 5'd16);
      run_mem_op("b2b_sw", 1'b1, 3'b010, 32'h604, 32'h0BAD_CAFE, 32'h0, 5'd17, 1, 1'b0, sc);
      idle_inputs();
      tick();
      total++; if ({out_valid, rd_out} !== 6'd0) $display("[TB] FAIL bubble outputs: got %h want 0", {out_valid, rd_out}); else passed++;
   endtask

   task automatic test_random();
      int sc;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            run_alu_op("rand_alu", $urandom, 5'($urandom_range(0, 31)));
         end else begin
            run_mem_op("rand_mem", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                       $urandom, $urandom, 5'($urandom_range(1, 31)), $urandom_range(0, 3),
                       $urandom_range(0, 7) == 0, sc);
         end
      end
      idle_inputs();
      tick();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int busy_cycles;
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2;
      alu_result = 32'h700; rd_in = 5'd20;
      tick();
      busy_cycles = 0;
      while (dmem_req === 1'b1 && busy_cycles < 20) begin
         busy_cycles++;
         if (busy_cycles == 8) begin
            total++; if (stall !== 1'b0) $display("[TB] FAIL timeout stall: got %0b want 0", stall); else passed++;
         end
         tick();
         if (busy_cycles == 8) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      total++; if (busy_cycles !== 8) $display("[TB] FAIL timeout busy_cycles: got %0d want 8", busy_cycles); else passed++;
      total++; if (bus_err !== 1'b1) $display("[TB] FAIL timeout bus_err: got %0b want 1", bus_err); else passed++;
      total++; if (out_valid !== 1'b1 || rd_out !== 5'd0) $display("[TB] FAIL timeout result: got valid=%0b rd=%0d want valid=1 rd=0", out_valid, rd_out); else passed++;
      tick();
      total++; if (bus_err !== 1'b0) $display("[TB] FAIL timeout bus_err pulse: got %0b want 0", bus_err); else passed++;
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_reset_busy();
      test_back_to_back();
      test_load_format();
      test_store_half();
      test_misalign();
      test_flush();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
